// File: rtl/sin_adc_pkg.sv
// Shared widths, sample field layout and FSM states for the sine-sample link receiver.
package sin_adc_pkg;

    localparam int SAMPLE_W = 16;
    localparam int BYTE_W   = 8;

    localparam int C_BIT = 15;
    localparam int D_BIT = 14;
    localparam int E_MSB = 13;
    localparam int E_LSB = 12;
    localparam int F_MSB = 11;
    localparam int F_LSB = 8;
    localparam int G_MSB = 7;
    localparam int G_LSB = 0;

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_COLLECT = 1'b1
    } state_t;

    // High beat carries the C/D/E/F fields, low beat carries G.
    function automatic logic [BYTE_W-1:0] hi_byte(input logic [SAMPLE_W-1:0] s);
        return {s[C_BIT], s[D_BIT], s[E_MSB:E_LSB], s[F_MSB:F_LSB]};
    endfunction

    function automatic logic [BYTE_W-1:0] lo_byte(input logic [SAMPLE_W-1:0] s);
        return s[G_MSB:G_LSB];
    endfunction

endpackage

// File: rtl/adc_byte_to_sin_reassembler_sat_counter.sv
// Saturating event counter: counts up on inc and holds at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    // Increment unless already at the ceiling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= {W{1'b0}};
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/adc_byte_to_sin_reassembler.sv
// Rebuilds 16-bit samples from REP repeated hi/lo byte pairs, votes later copies
// against copy 0 and presents the result on a valid/ready output.
module adc_byte_to_sin_reassembler
    import sin_adc_pkg::*;
#(
    parameter int REP   = 2,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BYTE_W-1:0]   in_data,
    input  logic                in_sop,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SAMPLE_W-1:0] out_sample,
    output logic                out_mismatch,
    output logic [CNT_W-1:0]    mism_cnt,
    output logic [CNT_W-1:0]    sync_cnt
);

    localparam int BEATS = 2 * REP;
    localparam int CW    = $clog2(BEATS);
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_cnt_nxt;
    logic [SAMPLE_W-1:0] r_sample;
    logic [SAMPLE_W-1:0] w_sample_nxt;
    logic [SAMPLE_W-1:0] w_sample_upd;
    logic                r_flag;
    logic                w_flag_nxt;
    logic                w_flag_upd;
    logic [BYTE_W-1:0]   w_ref_byte;
    logic                w_load;
    logic                w_sync_inc;
    logic                w_accept;
    logic                r_run;
    logic                r_out_valid;
    logic [SAMPLE_W-1:0] r_out_sample;
    logic                r_out_mismatch;

    // r_run keeps in_ready low while reset is applied and for the release edge.
    assign in_ready = r_run && !(r_out_valid && !out_ready);
    assign w_accept = in_valid && in_ready;

    // State and frame-assembly registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= {CW{1'b0}};
            r_sample <= {SAMPLE_W{1'b0}};
            r_flag   <= 1'b0;
            r_run    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_sample <= w_sample_nxt;
            r_flag   <= w_flag_nxt;
            r_run    <= 1'b1;
        end
    end

    // Next-state, byte placement and copy voting for each accepted beat.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_sample_nxt = r_sample;
        w_flag_nxt   = r_flag;
        w_sample_upd = r_sample;
        w_flag_upd   = r_flag;
        w_load       = 1'b0;
        w_sync_inc   = 1'b0;
        w_ref_byte   = r_cnt[0] ? lo_byte(r_sample) : hi_byte(r_sample);

        if (w_accept) begin
            case (r_state)
                S_IDLE: begin
                    if (in_sop) begin
                        w_sample_nxt = {in_data, r_sample[G_MSB:G_LSB]};
                        w_cnt_nxt    = CW'(1);
                        w_flag_nxt   = 1'b0;
                        w_state_nxt  = S_COLLECT;
                    end else begin
                        w_sync_inc = 1'b1;
                    end
                end
                S_COLLECT: begin
                    if (in_sop) begin
                        // Restart: the SOP beat becomes beat 0 of a fresh frame.
                        w_sync_inc   = 1'b1;
                        w_sample_nxt = {in_data, r_sample[G_MSB:G_LSB]};
                        w_cnt_nxt    = CW'(1);
                        w_flag_nxt   = 1'b0;
                    end else begin
                        if (r_cnt > CW'(1)) begin
                            w_flag_upd = r_flag | (in_data != w_ref_byte);
                        end else if (r_cnt[0]) begin
                            w_sample_upd[G_MSB:G_LSB] = in_data;
                        end else begin
                            w_sample_upd[C_BIT:F_LSB] = in_data;
                        end

                        if (r_cnt == LAST) begin
                            w_load       = 1'b1;
                            w_cnt_nxt    = {CW{1'b0}};
                            w_flag_nxt   = 1'b0;
                            w_sample_nxt = w_sample_upd;
                            w_state_nxt  = S_IDLE;
                        end else begin
                            w_cnt_nxt    = r_cnt + CW'(1);
                            w_flag_nxt   = w_flag_upd;
                            w_sample_nxt = w_sample_upd;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = {CW{1'b0}};
                    w_flag_nxt  = 1'b0;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Output register: a new load wins over a transfer so back-to-back keeps valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid    <= 1'b0;
            r_out_sample   <= {SAMPLE_W{1'b0}};
            r_out_mismatch <= 1'b0;
        end else if (w_load) begin
            r_out_valid    <= 1'b1;
            r_out_sample   <= w_sample_upd;
            r_out_mismatch <= w_flag_upd;
        end else if (r_out_valid && out_ready) begin
            r_out_valid    <= 1'b0;
        end else begin
            r_out_valid    <= r_out_valid;
        end
    end

    assign out_valid    = r_out_valid;
    assign out_sample   = r_out_sample;
    assign out_mismatch = r_out_mismatch;

    sat_counter #(.W(CNT_W)) u_mism_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_load && w_flag_upd),
        .count (mism_cnt)
    );

    sat_counter #(.W(CNT_W)) u_sync_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_sync_inc),
        .count (sync_cnt)
    );

endmodule

// File: tb/tb_adc_byte_to_sin_reassembler.sv
// Scoreboard bench: stimulus pushes expected samples, a negedge monitor pops and compares on transfer.
module tb_adc_byte_to_sin_reassembler;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_sop;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sample;
    logic        out_mismatch;
    logic [7:0]  mism_cnt;
    logic [7:0]  sync_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    logic [16:0] exp_q[$];

    adc_byte_to_sin_reassembler #(.REP(2), .CNT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_sop       (in_sop),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sample   (out_sample),
        .out_mismatch (out_mismatch),
        .mism_cnt     (mism_cnt),
        .sync_cnt     (sync_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every output transfer must match the oldest expected sample.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", {15'd0, out_sample, out_mismatch}, 32'hFFFF_FFFF);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                chk("out_sample", {16'd0, out_sample}, {16'd0, e[16:1]});
                chk("out_mismatch", {31'd0, out_mismatch}, {31'd0, e[0]});
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_beat(input logic [7:0] d, input logic s);
        logic ok;
        int   k;
        ok = 1'b0;
        k  = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_sop   = s;
        while (!ok && k < 200) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            k++;
        end
        if (!ok) chk("beat_timeout", {31'd0, ok}, 32'd1);
        in_valid = 1'b0;
        in_sop   = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] h0, input logic [7:0] l0,
                              input logic [7:0] h1, input logic [7:0] l1);
        send_beat(h0, 1'b1);
        send_beat(l0, 1'b0);
        send_beat(h1, 1'b0);
        send_beat(l1, 1'b0);
        chk("latency_out_valid", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_sop    = 1'b0;
        out_ready = 1'b1;
        idle(2);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_sample", {16'd0, out_sample}, 32'd0);
        chk("rst_counters", {16'd0, mism_cnt, sync_cnt}, 32'd0);
        rst_n = 1'b1;
        idle(1);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // 1: clean frame
        exp_q.push_back({16'hA53C, 1'b0});
        send_frame(8'hA5, 8'h3C, 8'hA5, 8'h3C);
        idle(2);
        chk("t1_counters", {16'd0, mism_cnt, sync_cnt}, 32'd0);

        // 2: last-beat mismatch
        exp_q.push_back({16'hA53C, 1'b1});
        send_frame(8'hA5, 8'h3C, 8'hA5, 8'h3D);
        idle(2);
        chk("t2_mism_cnt", {24'd0, mism_cnt}, 32'd1);

        // 2b: high-byte mismatch in copy 1
        exp_q.push_back({16'h1234, 1'b1});
        send_frame(8'h12, 8'h34, 8'h13, 8'h34);
        idle(2);
        chk("t2b_mism_cnt", {24'd0, mism_cnt}, 32'd2);

        // 3: resync on SOP mid-frame
        exp_q.push_back({16'h5678, 1'b0});
        send_beat(8'h12, 1'b1);
        send_beat(8'h34, 1'b0);
        send_frame(8'h56, 8'h78, 8'h56, 8'h78);
        idle(2);
        chk("t3_sync_cnt", {24'd0, sync_cnt}, 32'd1);
        chk("t3_mism_cnt", {24'd0, mism_cnt}, 32'd2);

        // 4: output held under backpressure
        out_ready = 1'b0;
        exp_q.push_back({16'hBEEF, 1'b0});
        send_frame(8'hBE, 8'hEF, 8'hBE, 8'hEF);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t4_hold_in_ready", {31'd0, in_ready}, 32'd0);
            chk("t4_hold_sample", {15'd0, out_valid, out_sample}, {15'd0, 1'b1, 16'hBEEF});
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("t4_released_valid", {31'd0, out_valid}, 32'd0);
        chk("t4_released_in_ready", {31'd0, in_ready}, 32'd1);

        // 5: stray beats in idle saturate sync_cnt without output
        for (int i = 0; i < 300; i++) send_beat(i[7:0], 1'b0);
        idle(1);
        chk("t5_sync_sat", {24'd0, sync_cnt}, 32'd255);
        chk("t5_no_valid", {31'd0, out_valid}, 32'd0);

        // 6: reset mid-frame
        send_beat(8'h11, 1'b1);
        send_beat(8'h22, 1'b0);
        send_beat(8'h11, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_outputs", {13'd0, in_ready, out_valid, out_mismatch, out_sample},
            {13'd0, 3'b000, 16'h0000});
        chk("t6_rst_counters", {16'd0, mism_cnt, sync_cnt}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        exp_q.push_back({16'h0001, 1'b0});
        send_frame(8'h00, 8'h01, 8'h00, 8'h01);
        idle(3);
        chk("t6_counters", {16'd0, mism_cnt, sync_cnt}, 32'd0);

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
